// File: rtl/execute_unit.sv
// Multi-cycle execute stage: single-cycle ALU ops plus iterative shifts and
// shift-add multiply, writing one result per accepted op to the register file.
module execute_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [3:0]       dest,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] D,
  output logic [3:0]       DA,
  output logic             RW,
  output logic             busy,
  output logic             done,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_MOVA = 4'h0;
  localparam logic [3:0] OP_INC  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_DEC  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_NOT  = 4'h8;
  localparam logic [3:0] OP_MOVB = 4'h9;
  localparam logic [3:0] OP_SHR  = 4'hA;
  localparam logic [3:0] OP_SHL  = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [3:0]       r_op;
  logic [3:0]       r_dest;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [CNT_W-1:0] r_cnt;

  logic             w_start_run;
  logic             w_reserved;
  logic [WIDTH-1:0] w_addend;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic             w_add_v;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_c;
  logic             w_alu_v;

  logic [WIDTH-1:0] w_sh_res;
  logic             w_sh_out;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;
  logic             w_last;
  logic [WIDTH-1:0] w_run_res;
  logic             w_run_c;
  logic             w_run_v;

  assign w_reserved  = (op > OP_MUL);
  assign w_start_run = (op == OP_MUL) ||
                       (((op == OP_SHR) || (op == OP_SHL)) && (B[3:0] != 4'd0));

  // Single-cycle result straight from the operand inputs at capture
  always_comb begin
    w_addend  = B;
    w_cin     = 1'b0;
    w_alu_res = A;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (op)
      OP_INC:  w_addend = WIDTH'(1);
      OP_SUB:  begin w_addend = ~B; w_cin = 1'b1; end
      OP_DEC:  w_addend = '1;
      default: w_addend = B;
    endcase
    w_sum   = {1'b0, A} + {1'b0, w_addend} + (WIDTH + 1)'(w_cin);
    w_add_v = (A[WIDTH-1] == w_addend[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
    case (op)
      OP_MOVA: w_alu_res = A;
      OP_INC, OP_ADD, OP_SUB, OP_DEC: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = w_add_v;
      end
      OP_AND:  w_alu_res = A & B;
      OP_OR:   w_alu_res = A | B;
      OP_XOR:  w_alu_res = A ^ B;
      OP_NOT:  w_alu_res = ~A;
      OP_MOVB: w_alu_res = B;
      default: w_alu_res = A;
    endcase
  end

  // One iteration step; on the final step its outputs are the written result
  always_comb begin
    w_sh_res  = (r_op == OP_SHR) ? (r_a >> 1) : (r_a << 1);
    w_sh_out  = (r_op == OP_SHR) ? r_a[0] : r_a[WIDTH-1];
    w_mul_sum = {1'b0, r_hi} + (r_b[0] ? {1'b0, r_a} : '0);
    w_mul_hi  = w_mul_sum[WIDTH:1];
    w_mul_lo  = {w_mul_sum[0], r_b[WIDTH-1:1]};
    w_last    = (r_cnt == CNT_W'(1));
    if (r_op == OP_MUL) begin
      w_run_res = w_mul_lo;
      w_run_c   = |w_mul_hi;
      w_run_v   = |w_mul_hi;
    end else begin
      w_run_res = w_sh_res;
      w_run_c   = w_sh_out;
      w_run_v   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = w_start_run ? S_RUN : S_WB;
      S_RUN:   if (w_last) w_next_state = S_WB;
      S_WB:    w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Operand capture, iteration registers and registered write-port/flag outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op   <= '0;
      r_dest <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_hi   <= '0;
      r_cnt  <= '0;
      D      <= '0;
      DA     <= '0;
      RW     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      Z      <= 1'b0;
      N      <= 1'b0;
      C      <= 1'b0;
      V      <= 1'b0;
    end else begin
      RW   <= 1'b0;
      done <= 1'b0;
      busy <= (w_next_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op   <= op;
            r_dest <= dest;
            r_a    <= A;
            r_b    <= B;
            r_hi   <= '0;
            r_cnt  <= (op == OP_MUL) ? CNT_W'(WIDTH) : CNT_W'(B[3:0]);
            if (!w_start_run) begin
              done <= 1'b1;
              DA   <= dest;
              if (!w_reserved) begin
                RW <= 1'b1;
                D  <= w_alu_res;
                Z  <= (w_alu_res == '0);
                N  <= w_alu_res[WIDTH-1];
                C  <= w_alu_c;
                V  <= w_alu_v;
              end
            end
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_op == OP_MUL) begin
            r_hi <= w_mul_hi;
            r_b  <= w_mul_lo;
          end else begin
            r_a <= w_sh_res;
          end
          if (w_last) begin
            done <= 1'b1;
            RW   <= 1'b1;
            DA   <= r_dest;
            D    <= w_run_res;
            Z    <= (w_run_res == '0);
            N    <= w_run_res[WIDTH-1];
            C    <= w_run_c;
            V    <= w_run_v;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_unit.sv
// Randomized and directed bench for execute_unit against an arithmetic reference model.
module tb_execute_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [3:0]  dest;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] D;
  logic [3:0]  DA;
  logic        RW;
  logic        busy;
  logic        done;
  logic        Z;
  logic        N;
  logic        C;
  logic        V;

  int n_chk;
  int n_pass;

  // expected flag state, held across ops
  logic ef_z, ef_n, ef_c, ef_v;

  execute_unit #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dest(dest), .A(A), .B(B),
    .D(D), .DA(DA), .RW(RW), .busy(busy), .done(done),
    .Z(Z), .N(N), .C(C), .V(V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference: result, carry, overflow and latency from plain integer arithmetic
  task automatic model(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res, output logic c, output logic v,
                       output int lat, output bit rsv);
    int unsigned s;
    int          si;
    int          sa;
    int          sb;
    longint unsigned p;
    int          n;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    n   = int'(b & 16'h000F);
    res = a;
    c   = 1'b0;
    v   = 1'b0;
    lat = 1;
    rsv = 1'b0;
    s   = 0;
    si  = 0;
    case (o)
      4'h0: res = a;
      4'h1: begin s = int'(a) + 1;        si = sa + 1;  end
      4'h2: begin s = int'(a) + int'(b);  si = sa + sb; end
      4'h3: begin s = int'(a) + int'(16'(~b)) + 1; si = sa - sb; end
      4'h4: begin s = int'(a) + 65535;    si = sa - 1;  end
      4'h5: res = a & b;
      4'h6: res = a | b;
      4'h7: res = a ^ b;
      4'h8: res = ~a;
      4'h9: res = b;
      4'hA: begin
        res = a >> n;
        c   = (n == 0) ? 1'b0 : a[n-1];
        lat = n + 1;
      end
      4'hB: begin
        res = a << n;
        c   = (n == 0) ? 1'b0 : a[16-n];
        lat = n + 1;
      end
      4'hC: begin
        p   = longint'(a) * longint'(b);
        res = p[15:0];
        c   = (p[31:16] != 16'h0);
        v   = c;
        lat = 17;
      end
      default: rsv = 1'b1;
    endcase
    if (o >= 4'h1 && o <= 4'h4) begin
      res = s[15:0];
      c   = s[16];
      v   = (si > 32767) || (si < -32768);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_D"},  32'(D), 32'(0));
    chk({tag, "_DA"}, 32'(DA), 32'(0));
    chk({tag, "_RW"}, 32'(RW), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
    chk({tag, "_flags"}, 32'({Z, N, C, V}), 32'(0));
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any edge
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_idle_zero(tag);
    @(negedge clk);
    rst = 1'b0;
    ef_z = 1'b0; ef_n = 1'b0; ef_c = 1'b0; ef_v = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] d, input bit poke);
    logic [15:0] er;
    logic        ec;
    logic        ev;
    int          elat;
    bit          rsv;
    int          cyc;
    model(o, a, b, er, ec, ev, elat, rsv);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b; dest = d;
    @(negedge clk);
    start = 1'b0;
    op = 4'($urandom); A = 16'($urandom); B = 16'($urandom); dest = 4'($urandom);
    cyc = 1;
    chk("busy_rise", 32'(busy), 32'(1));
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 3) start = 1'b1;
      if (poke && cyc == 4) start = 1'b0;
    end
    chk("latency", 32'(cyc), 32'(elat));
    chk("done", 32'(done), 32'(1));
    chk("RW", 32'(RW), rsv ? 32'(0) : 32'(1));
    chk("DA", 32'(DA), 32'(d));
    if (!rsv) begin
      chk("D", 32'(D), 32'(er));
      ef_z = (er == 16'h0);
      ef_n = er[15];
      ef_c = ec;
      ef_v = ev;
    end
    chk("flags", 32'({Z, N, C, V}), 32'({ef_z, ef_n, ef_c, ef_v}));
    @(negedge clk);
    chk("done_drop", 32'(done), 32'(0));
    chk("RW_drop", 32'(RW), 32'(0));
    chk("busy_drop", 32'(busy), 32'(0));
    if (!rsv) chk("D_hold", 32'(D), 32'(er));
    if (poke) begin
      cyc = 0;
      repeat (4) begin
        @(negedge clk);
        if (done) cyc++;
      end
      chk("poke_no_extra_done", 32'(cyc), 32'(0));
    end
  endtask

  initial begin
    int saw;
    n_chk = 0; n_pass = 0;
    rst = 1'b1; start = 1'b0; op = 4'h0; dest = 4'h0; A = 16'h0; B = 16'h0;
    ef_z = 1'b0; ef_n = 1'b0; ef_c = 1'b0; ef_v = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    async_reset("rst_idle");

    run_op(4'h2, 16'h7FFF, 16'h0001, 4'd5, 1'b0);
    run_op(4'h3, 16'h0003, 16'h0003, 4'd1, 1'b0);
    run_op(4'h3, 16'h0000, 16'h0001, 4'd2, 1'b0);
    run_op(4'hB, 16'h8001, 16'h0004, 4'd3, 1'b0);
    run_op(4'hA, 16'h0003, 16'h0001, 4'd4, 1'b0);
    run_op(4'hB, 16'h1234, 16'h0000, 4'd6, 1'b0);
    run_op(4'hA, 16'h8000, 16'h000F, 4'd7, 1'b0);
    run_op(4'h4, 16'h8000, 16'h0000, 4'd8, 1'b0);
    run_op(4'h1, 16'hFFFF, 16'h0000, 4'd9, 1'b0);
    run_op(4'hC, 16'h0100, 16'h0101, 4'd10, 1'b1);
    run_op(4'hC, 16'h00FF, 16'h0003, 4'd11, 1'b0);
    run_op(4'hC, 16'hFFFF, 16'hFFFF, 4'd12, 1'b0);

    // Abort a multiply partway through RUN
    @(negedge clk);
    start = 1'b1; op = 4'hC; A = 16'h0100; B = 16'h0101; dest = 4'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("abort_in_run", 32'(busy), 32'(1));
    #2 rst = 1'b1;
    #1 chk_idle_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    ef_z = 1'b0; ef_n = 1'b0; ef_c = 1'b0; ef_v = 1'b0;
    saw = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || RW || busy) saw++;
    end
    chk("abort_quiet", 32'(saw), 32'(0));

    run_op(4'hE, 16'h1111, 16'h2222, 4'd14, 1'b0);
    run_op(4'h2, 16'h8000, 16'h8000, 4'd15, 1'b0);
    run_op(4'hF, 16'h0000, 16'h0000, 4'd0, 1'b0);

    for (int i = 0; i < 80; i++) begin
      run_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
             4'($urandom), 1'b0);
    end

    async_reset("rst_after_random");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
